// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_e;

    // A halt must let the three older instructions in EX, MEM and WB retire.
    localparam int DRAIN_CYCLES   = 3;
    // The 2-bit stall down-counter limits how many bubbles one load can request.
    localparam int LOAD_STALL_MAX = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
// Latency: count reflects increments up to the previous clock edge.
// Backpressure: none; inc_en is sampled every cycle.
//
// Ports: clk, rst_n (async clear), inc_en (count this cycle), count (value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencer: load-use stalls, branch flush, halt drain, memory freeze.
// Latency: enables are combinational from state and inputs; state updates next edge.
// Backpressure: mem_busy freezes every register and holds the sequencer state.
//
// Ports: hazard_i / branch_taken_EX / halt_ID / mem_busy in; PC, IF/ID and
// downstream pipe enables, IF/ID flush, ID/EX bubble, sticky halted and a
// saturating stall-cycle counter out.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int STALL_CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hazard_i,
    input  logic                   branch_taken_EX,
    input  logic                   halt_ID,
    input  logic                   mem_busy,
    output logic                   pc_write_en,
    output logic                   ifid_write_en,
    output logic                   ifid_flush,
    output logic                   idex_bubble,
    output logic                   pipe_write_en,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // Out-of-range settings are clamped into what the 2-bit counter can hold.
    localparam int LS_EFF = (LOAD_STALL_CYCLES < 1)              ? 1 :
                            (LOAD_STALL_CYCLES > LOAD_STALL_MAX) ? LOAD_STALL_MAX :
                                                                   LOAD_STALL_CYCLES;
    // The hazard cycle in RUN is the first bubble, so LDSTALL covers the rest.
    localparam logic [1:0] LS_CNT_INIT    = 2'(LS_EFF - 1);
    localparam logic [1:0] DRAIN_CNT_INIT = 2'(DRAIN_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic pc_we, ifid_we, flush, bubble, pipe_we, halt_st;
    logic stall_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        pipe_we = 1'b0;
        halt_st = 1'b0;

        if (state_q == HALTED) begin
            halt_st = 1'b1;
        end else if (mem_busy) begin
            // Freeze: every enable low, state and counter hold.
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken_EX) begin
                        // Younger hazard/halt are on the wrong path and are dropped.
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        flush   = 1'b1;
                        bubble  = 1'b1;
                        pipe_we = 1'b1;
                    end else if (hazard_i) begin
                        bubble  = 1'b1;
                        pipe_we = 1'b1;
                        if (LS_EFF > 1) begin
                            state_d = LDSTALL;
                            cnt_d   = LS_CNT_INIT;
                        end
                    end else if (halt_ID) begin
                        bubble  = 1'b1;
                        pipe_we = 1'b1;
                        state_d = DRAIN;
                        cnt_d   = DRAIN_CNT_INIT;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        pipe_we = 1'b1;
                    end
                end
                LDSTALL: begin
                    if (branch_taken_EX) begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                        flush   = 1'b1;
                        bubble  = 1'b1;
                        pipe_we = 1'b1;
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        bubble  = 1'b1;
                        pipe_we = 1'b1;
                        cnt_d   = cnt_q - 2'd1;
                        if (cnt_q == 2'd1) begin
                            state_d = RUN;
                        end
                    end
                end
                DRAIN: begin
                    // EX only holds bubbles here, so branch/hazard cannot be real.
                    bubble  = 1'b1;
                    pipe_we = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = HALTED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low for as long as reset is held, not only after an edge.
    assign pc_write_en   = rst_n & pc_we;
    assign ifid_write_en = rst_n & ifid_we;
    assign ifid_flush    = rst_n & flush;
    assign idex_bubble   = rst_n & bubble;
    assign pipe_write_en = rst_n & pipe_we;
    assign halted        = rst_n & halt_st;

    // Frozen cycles count as stalls; time spent halted does not.
    assign stall_inc = ~pc_we & (state_q != HALTED);

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc_en (stall_inc),
        .count  (stall_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n, hazard_i, branch_taken_EX, halt_ID, mem_busy;

    logic          pc1, ifid1, fl1, bub1, pipe1, hlt1;
    logic          pc3, ifid3, fl3, bub3, pipe3, hlt3;
    logic [CW-1:0] sc1, sc3;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(1), .STALL_CNT_W(CW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .hazard_i(hazard_i), .branch_taken_EX(branch_taken_EX),
        .halt_ID(halt_ID), .mem_busy(mem_busy), .pc_write_en(pc1), .ifid_write_en(ifid1),
        .ifid_flush(fl1), .idex_bubble(bub1), .pipe_write_en(pipe1), .halted(hlt1),
        .stall_cycles(sc1));

    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(3), .STALL_CNT_W(CW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .hazard_i(hazard_i), .branch_taken_EX(branch_taken_EX),
        .halt_ID(halt_ID), .mem_busy(mem_busy), .pc_write_en(pc3), .ifid_write_en(ifid3),
        .ifid_flush(fl3), .idex_bubble(bub3), .pipe_write_en(pipe3), .halted(hlt3),
        .stall_cycles(sc3));

    // Expected outputs are {pc, ifid, flush, bubble, pipe, halted}.
    typedef struct packed {
        logic [5:0]    outs;
        logic [CW-1:0] stall;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int errors = 0;
    int checks = 0;

    // Reference model: remaining stall bubbles, remaining drain cycles,
    // halted flag and a plain integer stall tally per instance.
    int m_bub[2];
    int m_drain[2];
    int m_stall[2];
    bit m_halt[2];
    int m_lcyc[2] = '{1, 3};

    localparam logic [5:0] O_RUN   = 6'b110010;
    localparam logic [5:0] O_FLUSH = 6'b111110;
    localparam logic [5:0] O_BUB   = 6'b000110;
    localparam logic [5:0] O_ZERO  = 6'b000000;
    localparam logic [5:0] O_HALT  = 6'b000001;

    task automatic model_step(input int k, input bit rst, input bit br, input bit hz,
                              input bit ht, input bit mb, output exp_t e);
        logic [5:0] o;
        if (!rst) begin
            m_bub[k] = 0; m_drain[k] = 0; m_stall[k] = 0; m_halt[k] = 0;
            e.outs = O_ZERO; e.stall = '0;
            return;
        end
        e.stall = CW'(m_stall[k]);
        if (m_halt[k]) begin
            o = O_HALT;
        end else if (mb) begin
            o = O_ZERO;
        end else if (m_drain[k] > 0) begin
            o = O_BUB;
            m_drain[k]--;
            if (m_drain[k] == 0) m_halt[k] = 1;
        end else if (m_bub[k] > 0) begin
            if (br) begin
                o = O_FLUSH;
                m_bub[k] = 0;
            end else begin
                o = O_BUB;
                m_bub[k]--;
            end
        end else if (br) begin
            o = O_FLUSH;
        end else if (hz) begin
            o = O_BUB;
            m_bub[k] = m_lcyc[k] - 1;
        end else if (ht) begin
            o = O_BUB;
            m_drain[k] = 3;
        end else begin
            o = O_RUN;
        end
        // Any cycle with the PC held (and not halted before it) costs one stall.
        if (!o[5] && o != O_HALT && m_stall[k] < 65535) m_stall[k]++;
        e.outs = o;
    endtask

    task automatic cyc(input bit rst, input bit br, input bit hz, input bit ht, input bit mb);
        exp_t e1, e3;
        @(posedge clk);
        #1;
        rst_n = rst; branch_taken_EX = br; hazard_i = hz; halt_ID = ht; mem_busy = mb;
        model_step(0, rst, br, hz, ht, mb, e1);
        model_step(1, rst, br, hz, ht, mb, e3);
        q1.push_back(e1);
        q3.push_back(e3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so one expectation is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            checks++;
            if ({pc1, ifid1, fl1, bub1, pipe1, hlt1} != e.outs) begin
                errors++;
                $display("FAIL outs_L1 t=%0t got=%b exp=%b", $time,
                         {pc1, ifid1, fl1, bub1, pipe1, hlt1}, e.outs);
            end
            checks++;
            if (sc1 != e.stall) begin
                errors++;
                $display("FAIL stall_L1 t=%0t got=%0d exp=%0d", $time, sc1, e.stall);
            end
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            checks++;
            if ({pc3, ifid3, fl3, bub3, pipe3, hlt3} != e.outs) begin
                errors++;
                $display("FAIL outs_L3 t=%0t got=%b exp=%b", $time,
                         {pc3, ifid3, fl3, bub3, pipe3, hlt3}, e.outs);
            end
            checks++;
            if (sc3 != e.stall) begin
                errors++;
                $display("FAIL stall_L3 t=%0t got=%0d exp=%0d", $time, sc3, e.stall);
            end
        end
    end

    initial begin
        rst_n = 1'b0; hazard_i = 1'b0; branch_taken_EX = 1'b0; halt_ID = 1'b0; mem_busy = 1'b0;

        // Reset state, including inputs that would otherwise assert enables.
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        idle(2);

        // Single load-use hazard.
        cyc(1, 0, 1, 0, 0);
        idle(4);

        // Branch beats a same-cycle hazard.
        cyc(1, 1, 1, 0, 0);
        idle(2);

        // Freeze in the middle of a load stall.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 1, 0, 1);
        cyc(1, 0, 1, 0, 1);
        idle(4);

        // Branch aborting a load stall.
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 0);
        idle(2);

        // Halt drain, then halted ignores everything.
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 1);
        idle(2);
        cyc(1, 1, 1, 0, 1);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        idle(1);

        // Reset mid-drain.
        cyc(1, 0, 0, 1, 0);
        idle(1);
        cyc(0, 0, 0, 0, 0);
        idle(3);

        // Halt with same-cycle branch is dropped.
        cyc(1, 1, 0, 1, 0);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit r;
            r = !((m_halt[0] && m_halt[1] && $urandom_range(0, 99) < 30) ||
                  $urandom_range(0, 199) == 0);
            cyc(r, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 15);
        end

        // Saturation of the stall counter under a long freeze.
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(1, 0, 0, 0, 1);
        idle(2);

        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (q1.size() != 0 || q3.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q1.size(), q3.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
